// File: rtl/pl_scr_pkg.sv
// Purpose: shared types, constants and helper functions for the PL symbol
//          scrambler (Gold-sequence seeds/taps, FSM states, I/Q rotation).
// Ports:   none (package).
package pl_scr_pkg;

   localparam int unsigned SEQ_W     = 18;
   localparam int unsigned SYM_W_MAX = 32;

   localparam logic [SEQ_W-1:0] X_SEED = 18'h00001;
   localparam logic [SEQ_W-1:0] Y_SEED = 18'h3FFFF;

   // Feedback taps: x0^x7 and y0^y5^y7^y10
   localparam logic [SEQ_W-1:0] X_FB_MASK = 18'h00081;
   localparam logic [SEQ_W-1:0] Y_FB_MASK = 18'h004A1;
   // Taps producing z(i+131072): x4^x6^x15 and y5^y6^y8..y15
   localparam logic [SEQ_W-1:0] X_Z_MASK  = 18'h08050;
   localparam logic [SEQ_W-1:0] Y_Z_MASK  = 18'h0FF60;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_e;

   typedef struct packed {
      logic signed [SYM_W_MAX-1:0] i;
      logic signed [SYM_W_MAX-1:0] q;
   } iq_t;

   // One shift of an 18-bit register holding x(i..i+17); bit 0 is x(i)
   function automatic logic [SEQ_W-1:0] lfsr_step(input logic [SEQ_W-1:0] r,
                                                  input logic [SEQ_W-1:0] fb_mask);
      return {^(r & fb_mask), r[SEQ_W-1:1]};
   endfunction

   function automatic logic [1:0] rn_of(input logic [SEQ_W-1:0] x,
                                        input logic [SEQ_W-1:0] y);
      return {(^(x & X_Z_MASK)) ^ (^(y & Y_Z_MASK)), x[0] ^ y[0]};
   endfunction

   // Negate a sign-extended w-bit value; the most negative code maps to max
   function automatic logic signed [SYM_W_MAX-1:0] sat_neg(
      input logic signed [SYM_W_MAX-1:0] v, input int unsigned w);
      logic signed [SYM_W_MAX-1:0] min_v;
      min_v = '1;
      min_v = min_v <<< (w - 1);
      return (v == min_v) ? ~min_v : -v;
   endfunction

   function automatic iq_t rotate(input iq_t s, input logic [1:0] rn,
                                  input int unsigned w);
      iq_t r;
      case (rn)
         2'd0: r = s;
         2'd1: begin
            r.i = sat_neg(s.q, w);
            r.q = s.i;
         end
         2'd2: begin
            r.i = sat_neg(s.i, w);
            r.q = sat_neg(s.q, w);
         end
         default: begin
            r.i = s.q;
            r.q = sat_neg(s.i, w);
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pl_symbol_scrambler_if.sv
// Purpose: symbol stream bundle around the scrambler: upstream symbol input
//          with handshake and downstream symbol output with handshake.
// Modports: slave  - scrambler view (consumes i_*, drives o_*)
//           master - environment view (drives i_*, consumes o_*)
interface pl_symbol_scrambler_if #(
   parameter int unsigned W = 8
) ();
   logic                i_valid;
   logic                o_ready;
   logic                i_sof;
   logic signed [W-1:0] i_i;
   logic signed [W-1:0] i_q;
   logic                o_valid;
   logic                i_ready;
   logic                o_sof;
   logic                o_hdr;
   logic signed [W-1:0] o_i;
   logic signed [W-1:0] o_q;

   modport slave (
      input  i_valid, i_sof, i_i, i_q, i_ready,
      output o_ready, o_valid, o_sof, o_hdr, o_i, o_q
   );

   modport master (
      output i_valid, i_sof, i_i, i_q, i_ready,
      input  o_ready, o_valid, o_sof, o_hdr, o_i, o_q
   );
endinterface

// File: rtl/pl_seq_gen.sv
// Purpose: PL Gold-sequence generator producing the 2-bit rotation index Rn.
// Ports:   clk_i    - clock
//          reset_i  - synchronous active-high reset (loads seeds)
//          reseed_i - reload seeds (index 0), wins over en_i
//          en_i     - advance the sequence one step
//          rn_o     - Rn for the current sequence index
module pl_seq_gen
   import pl_scr_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       reseed_i,
   input  logic       en_i,
   output logic [1:0] rn_o
);

   logic [SEQ_W-1:0] x_q, x_d;
   logic [SEQ_W-1:0] y_q, y_d;
   logic [1:0]       rn_q;

   // Next register contents
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (reseed_i) begin
         x_d = X_SEED;
         y_d = Y_SEED;
      end else if (en_i) begin
         x_d = lfsr_step(x_q, X_FB_MASK);
         y_d = lfsr_step(y_q, Y_FB_MASK);
      end
   end

   // Rn is registered alongside the state it is derived from
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         x_q  <= X_SEED;
         y_q  <= Y_SEED;
         rn_q <= rn_of(X_SEED, Y_SEED);
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         rn_q <= rn_of(x_d, y_d);
      end
   end

   assign rn_o = rn_q;

endmodule

// File: rtl/pl_symbol_scrambler.sv
// Purpose: passes PL headers unchanged and rotates every data symbol by the
//          Gold-sequence value Rn; sequence reseeded on each frame start.
// Ports:   i_clk   - clock
//          i_reset - synchronous active-high reset
//          bus     - symbol stream (slave): i_valid/o_ready/i_sof/i_i/i_q in,
//                    o_valid/i_ready/o_sof/o_hdr/o_i/o_q out
module pl_symbol_scrambler
   import pl_scr_pkg::*;
#(
   parameter int unsigned W       = 8,
   parameter int unsigned HDR_LEN = 320,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   pl_symbol_scrambler_if.slave  bus
);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                o_valid_q, o_valid_d;
   logic                o_sof_q, o_sof_d;
   logic                o_hdr_q, o_hdr_d;
   logic signed [W-1:0] o_i_q, o_i_d;
   logic signed [W-1:0] o_q_q, o_q_d;
   logic                ready_c;
   logic                accept_c;
   logic                seq_reseed_c;
   logic                seq_adv_c;
   logic [1:0]          rn;
   iq_t                 in_iq;
   iq_t                 rot_iq;

   // Single output stage: accept whenever it is empty or being drained
   assign ready_c  = ~o_valid_q | bus.i_ready;
   assign accept_c = bus.i_valid & ready_c;

   assign in_iq.i = SYM_W_MAX'(bus.i_i);
   assign in_iq.q = SYM_W_MAX'(bus.i_q);
   assign rot_iq  = rotate(in_iq, rn, W);

   pl_seq_gen u_seq (
      .clk_i    (i_clk),
      .reset_i  (i_reset),
      .reseed_i (seq_reseed_c),
      .en_i     (seq_adv_c),
      .rn_o     (rn)
   );

   // Next-state and output-register logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      seq_reseed_c = 1'b0;
      seq_adv_c    = 1'b0;
      o_valid_d    = o_valid_q;
      o_sof_d      = o_sof_q;
      o_hdr_d      = o_hdr_q;
      o_i_d        = o_i_q;
      o_q_d        = o_q_q;

      if (accept_c) begin
         o_valid_d = 1'b1;
         o_sof_d   = bus.i_sof;
         o_hdr_d   = 1'b1;
         o_i_d     = bus.i_i;
         o_q_d     = bus.i_q;
         if (bus.i_sof) begin
            // Frame (re)start from any state; sof symbol counts as header #1
            seq_reseed_c = 1'b1;
            cnt_d        = CNT_W'(1);
            state_d      = (HDR_LEN == 1) ? DATA : HDR;
         end else begin
            case (state_q)
               HDR: begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(HDR_LEN - 1)) begin
                     state_d = DATA;
                  end
               end
               DATA: begin
                  seq_adv_c = 1'b1;
                  o_hdr_d   = 1'b0;
                  o_i_d     = W'(rot_iq.i);
                  o_q_d     = W'(rot_iq.q);
               end
               default: ;
            endcase
         end
      end else if (bus.i_ready) begin
         o_valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         o_valid_q <= 1'b0;
         o_sof_q   <= 1'b0;
         o_hdr_q   <= 1'b1;
         o_i_q     <= '0;
         o_q_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         o_valid_q <= o_valid_d;
         o_sof_q   <= o_sof_d;
         o_hdr_q   <= o_hdr_d;
         o_i_q     <= o_i_d;
         o_q_q     <= o_q_d;
      end
   end

   assign bus.o_ready = ready_c;
   assign bus.o_valid = o_valid_q;
   assign bus.o_sof   = o_sof_q;
   assign bus.o_hdr   = o_hdr_q;
   assign bus.o_i     = o_i_q;
   assign bus.o_q     = o_q_q;

endmodule

// File: tb/tb_pl_symbol_scrambler.sv
// Purpose: self-checking bench for pl_symbol_scrambler; reference model works
//          from the sequence recurrences z(n) = x(n)^y(n), Rn = 2z(n+131072)+z(n)
//          and rotation as repeated multiplication by j with final clipping.
module tb_pl_symbol_scrambler;

   localparam int unsigned W    = 8;
   localparam int unsigned HL   = 5;
   localparam int          MAXV = (1 << (W - 1)) - 1;
   localparam int          OFS  = 131072;
   localparam int          NIDX = 4096;
   localparam int          LAST = OFS + NIDX + 17;

   logic clk = 1'b0;
   logic rst;
   logic rst1;

   always #5 clk = ~clk;

   pl_symbol_scrambler_if #(.W(W)) bus  ();
   pl_symbol_scrambler_if #(.W(W)) bus1 ();

   pl_symbol_scrambler #(.W(W), .HDR_LEN(HL), .CNT_W(16)) u_dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   pl_symbol_scrambler #(.W(W), .HDR_LEN(1), .CNT_W(16)) u_dut1 (
      .i_clk   (clk),
      .i_reset (rst1),
      .bus     (bus1)
   );

   int checks;
   int errors;

   bit xs [0:LAST];
   bit ys [0:LAST];

   // Model of the observable output register and frame position
   bit                  m_valid;
   bit                  m_sof;
   bit                  m_hdr;
   logic signed [W-1:0] m_i;
   logic signed [W-1:0] m_q;
   bit                  in_frame;
   int                  pos;
   int                  n_idx;

   function automatic int rn_ref(input int n);
      return 2 * int'(xs[n + OFS] ^ ys[n + OFS]) + int'(xs[n] ^ ys[n]);
   endfunction

   task automatic rot_ref(input int rn, input int ii, input int qq,
                          output int oi, output int oq);
      int a, b, t;
      a = ii;
      b = qq;
      for (int k = 0; k < rn; k++) begin
         t = a;
         a = -b;
         b = t;
      end
      oi = (a > MAXV) ? MAXV : a;
      oq = (b > MAXV) ? MAXV : b;
   endtask

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock of the main DUT: drive, compare current outputs, clock, update model
   task automatic cycle(input bit r, input bit v, input bit s, input int ii,
                        input int qq, input bit rdy);
      int  oi, oq;
      bit  acc;
      rst         = r;
      bus.i_valid = v;
      bus.i_sof   = s;
      bus.i_i     = W'(ii);
      bus.i_q     = W'(qq);
      bus.i_ready = rdy;
      #1;
      check("o_ready", 32'(bus.o_ready), 32'(!m_valid || rdy));
      check("o_valid", 32'(bus.o_valid), 32'(m_valid));
      if (m_valid) begin
         check("o_sof", 32'(bus.o_sof), 32'(m_sof));
         check("o_hdr", 32'(bus.o_hdr), 32'(m_hdr));
         check("o_i",   32'(bus.o_i),   32'(m_i));
         check("o_q",   32'(bus.o_q),   32'(m_q));
      end
      acc = v && (!m_valid || rdy);
      @(posedge clk);
      #1;
      if (r) begin
         m_valid  = 0;
         m_sof    = 0;
         m_hdr    = 1;
         m_i      = '0;
         m_q      = '0;
         in_frame = 0;
      end else if (acc) begin
         m_valid = 1;
         m_sof   = s;
         m_hdr   = 1;
         m_i     = W'(ii);
         m_q     = W'(qq);
         if (s) begin
            in_frame = 1;
            pos      = 1;
            n_idx    = 0;
         end else if (in_frame) begin
            if (pos < HL) begin
               pos++;
            end else begin
               rot_ref(rn_ref(n_idx), ii, qq, oi, oq);
               n_idx++;
               m_hdr = 0;
               m_i   = W'(oi);
               m_q   = W'(oq);
            end
         end
      end else if (rdy) begin
         m_valid = 0;
      end
   endtask

   task automatic frame_start(input int ii, input int qq);
      cycle(0, 1, 1, ii, qq, 1);
      repeat (HL - 1) cycle(0, 1, 0, ii, qq, 1);
   endtask

   initial begin
      int  oi, oq, rn, cyc, ri, rq;
      bit  h1, h2, v, rdy;

      checks = 0;
      errors = 0;
      for (int k = 0; k < 18; k++) begin
         xs[k] = (k == 0);
         ys[k] = 1'b1;
      end
      for (int k = 0; k + 18 <= LAST; k++) begin
         xs[k + 18] = xs[k + 7] ^ xs[k];
         ys[k + 18] = ys[k] ^ ys[k + 5] ^ ys[k + 7] ^ ys[k + 10];
      end

      bus.i_valid  = 0; bus.i_sof  = 0; bus.i_i  = '0; bus.i_q  = '0; bus.i_ready  = 1;
      bus1.i_valid = 0; bus1.i_sof = 0; bus1.i_i = '0; bus1.i_q = '0; bus1.i_ready = 1;
      rst  = 1;
      rst1 = 1;
      repeat (3) @(posedge clk);
      #1;
      m_valid = 0; m_sof = 0; m_hdr = 1; m_i = '0; m_q = '0;
      in_frame = 0; pos = 0; n_idx = 0;

      // Reset state
      check("rst_o_valid", 32'(bus.o_valid), 32'd0);
      check("rst_o_sof",   32'(bus.o_sof),   32'd0);
      check("rst_o_hdr",   32'(bus.o_hdr),   32'd1);
      check("rst_o_i",     32'(bus.o_i),     32'd0);
      check("rst_o_q",     32'(bus.o_q),     32'd0);
      check("rst_o_ready", 32'(bus.o_ready), 32'd1);

      // Out-of-frame symbols, then header + first data symbol
      cycle(0, 1, 0, 9, -9, 1);
      frame_start(5, -3);
      cycle(0, 1, 0, 5, -3, 1);
      rot_ref(rn_ref(0), 5, -3, oi, oq);
      check("first_data_hdr", 32'(bus.o_hdr), 32'd0);
      check("first_data_i",   32'(bus.o_i),   32'(oi));
      check("first_data_q",   32'(bus.o_q),   32'(oq));
      cycle(0, 0, 0, 0, 0, 1);

      // Saturating negation of the most negative code
      frame_start(1, 2);
      h1 = 0;
      h2 = 0;
      for (int k = 0; k < 64; k++) begin
         rn = rn_ref(k);
         if (rn == 2 && !h2) begin
            cycle(0, 1, 0, -128, 0, 1);
            check("sat_rn2_i", 32'(bus.o_i), 32'(127));
            check("sat_rn2_q", 32'(bus.o_q), 32'(0));
            h2 = 1;
         end else if (rn == 1 && !h1) begin
            cycle(0, 1, 0, 0, -128, 1);
            check("sat_rn1_i", 32'(bus.o_i), 32'(127));
            check("sat_rn1_q", 32'(bus.o_q), 32'(0));
            h1 = 1;
         end else begin
            cycle(0, 1, 0, k, -k, 1);
         end
      end
      cycle(0, 0, 0, 0, 0, 1);

      // 1000 random data symbols with random valid/ready stalls
      frame_start(3, 4);
      cyc = 0;
      while (n_idx < 1000 && cyc < 8000) begin
         v   = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         ri  = int'($urandom_range(0, 255)) - 128;
         rq  = int'($urandom_range(0, 255)) - 128;
         cycle(0, v, v ? 1'b0 : 1'($urandom_range(0, 1)), ri, rq, rdy);
         cyc++;
      end
      check("rand_data_count", 32'(n_idx), 32'd1000);
      cycle(0, 0, 0, 0, 0, 1);

      // sof after 37 data symbols restarts the sequence
      frame_start(6, 7);
      for (int k = 0; k < 37; k++) cycle(0, 1, 0, k + 1, 2 * k, 1);
      frame_start(6, 7);
      cycle(0, 1, 0, 5, -3, 1);
      rot_ref(rn_ref(0), 5, -3, oi, oq);
      check("restart_i", 32'(bus.o_i), 32'(oi));
      check("restart_q", 32'(bus.o_q), 32'(oq));
      cycle(0, 1, 0, 11, 22, 1);

      // sof mid-header restarts the header count
      cycle(0, 1, 1, 1, 1, 1);
      cycle(0, 1, 0, 1, 1, 1);
      frame_start(2, 2);
      cycle(0, 1, 0, 40, -50, 1);
      cycle(0, 1, 0, -60, 70, 1);

      // Reset while a data symbol is held by downstream back-pressure
      cycle(0, 1, 0, 33, 44, 1);
      cycle(0, 1, 0, 55, 66, 0);
      cycle(0, 1, 1, 55, 66, 0);
      cycle(1, 1, 0, 55, 66, 0);
      check("midrst_o_valid", 32'(bus.o_valid), 32'd0);
      check("midrst_o_hdr",   32'(bus.o_hdr),   32'd1);
      cycle(0, 1, 0, 12, -34, 1);
      check("postrst_hdr", 32'(bus.o_hdr), 32'd1);
      check("postrst_i",   32'(bus.o_i),   32'(12));
      cycle(0, 1, 0, -128, 77, 1);
      cycle(1, 1, 0, 1, 1, 1);
      cycle(0, 0, 0, 0, 0, 1);

      // HDR_LEN=1 instance: symbol after sof is already data
      rst1 = 0;
      bus1.i_valid = 1; bus1.i_sof = 1; bus1.i_i = W'(5); bus1.i_q = W'(-3);
      @(posedge clk);
      #1;
      check("h1_sof_valid", 32'(bus1.o_valid), 32'd1);
      check("h1_sof_sof",   32'(bus1.o_sof),   32'd1);
      check("h1_sof_hdr",   32'(bus1.o_hdr),   32'd1);
      check("h1_sof_i",     32'(bus1.o_i),     32'(5));
      check("h1_sof_q",     32'(bus1.o_q),     32'(-3));
      bus1.i_sof = 0;
      @(posedge clk);
      #1;
      rot_ref(rn_ref(0), 5, -3, oi, oq);
      check("h1_d0_hdr", 32'(bus1.o_hdr), 32'd0);
      check("h1_d0_sof", 32'(bus1.o_sof), 32'd0);
      check("h1_d0_i",   32'(bus1.o_i),   32'(oi));
      check("h1_d0_q",   32'(bus1.o_q),   32'(oq));
      bus1.i_i = W'(-128); bus1.i_q = W'(19);
      @(posedge clk);
      #1;
      rot_ref(rn_ref(1), -128, 19, oi, oq);
      check("h1_d1_i", 32'(bus1.o_i), 32'(oi));
      check("h1_d1_q", 32'(bus1.o_q), 32'(oq));
      bus1.i_valid = 0;
      @(posedge clk);
      #1;
      check("h1_drain_valid", 32'(bus1.o_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
